// File: rtl/matrix_mac_pkg.sv
// Shared definitions for the matrix MAC datapath: matrix geometry, loader
// state encoding and the operand matrix type used on loader/MAC ports.
package matrix_mac_pkg;

  localparam int MATRIX_DIM = 4;
  localparam int ELEMS      = MATRIX_DIM * MATRIX_DIM;
  localparam int ELEM_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    CLEAR,
    FIRE
  } loader_state_e;

  typedef logic [0:MATRIX_DIM-1][0:MATRIX_DIM-1][ELEM_WIDTH-1:0] matrix_t;

endpackage

// File: rtl/matrix_operand_loader.sv
// Streams two row-major 4x4 operand matrices into registers and issues the
// MAC's clear/enable strobes, counting passes and flagging framing errors.
module matrix_operand_loader
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [DATA_WIDTH-1:0]                              in_data,
  input  logic                                               in_first,
  input  logic                                               in_clear,
  output logic [0:MATRIX_DIM-1][0:MATRIX_DIM-1][DATA_WIDTH-1:0] matrix_1,
  output logic [0:MATRIX_DIM-1][0:MATRIX_DIM-1][DATA_WIDTH-1:0] matrix_2,
  output logic                                               mac_clear,
  output logic                                               mac_enable,
  output logic [7:0]                                         pass_count,
  output logic                                               frame_error
);

  localparam int IDX_W = $clog2(ELEMS);

  loader_state_e state_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [0:MATRIX_DIM-1][0:MATRIX_DIM-1][DATA_WIDTH-1:0] m1_q, m2_q;
  logic mac_clear_q, mac_enable_q, frame_error_q, clear_pending_q;
  logic [7:0] pass_q;

  logic ready;
  logic accept;
  logic resync;
  logic last_beat;

  always_comb begin
    ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
    accept    = in_valid && ready;
    // A frame start anywhere but A[0][0] restarts the frame at A[0][0]
    resync    = accept && in_first && ((idx_q != '0) || (state_q == LOAD_B));
    last_beat = (idx_q == IDX_W'(ELEMS - 1));
    idx_d     = idx_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= LOAD_A;
      idx_q           <= '0;
      m1_q            <= '0;
      m2_q            <= '0;
      mac_clear_q     <= 1'b0;
      mac_enable_q    <= 1'b0;
      pass_q          <= '0;
      frame_error_q   <= 1'b0;
      clear_pending_q <= 1'b0;
    end else begin
      mac_clear_q  <= 1'b0;
      mac_enable_q <= 1'b0;
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (resync) begin
            frame_error_q   <= 1'b1;
            m1_q[0][0]      <= in_data;
            idx_q           <= IDX_W'(1);
            state_q         <= LOAD_A;
            clear_pending_q <= in_clear;
          end else if (accept) begin
            idx_q <= idx_d;
            if (state_q == LOAD_A) begin
              m1_q[idx_q[3:2]][idx_q[1:0]] <= in_data;
              if (in_first) clear_pending_q <= in_clear;
              if (last_beat) state_q <= LOAD_B;
            end else begin
              m2_q[idx_q[3:2]][idx_q[1:0]] <= in_data;
              if (last_beat) begin
                // Strobes are loaded on the transition so each lines up with its state
                if (clear_pending_q) begin
                  state_q     <= CLEAR;
                  mac_clear_q <= 1'b1;
                end else begin
                  state_q      <= FIRE;
                  mac_enable_q <= 1'b1;
                end
              end
            end
          end
        end
        CLEAR: begin
          pass_q          <= '0;
          clear_pending_q <= 1'b0;
          mac_enable_q    <= 1'b1;
          state_q         <= FIRE;
        end
        FIRE: begin
          pass_q  <= pass_q + 8'd1;
          state_q <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign in_ready    = ready;
  assign matrix_1    = m1_q;
  assign matrix_2    = m2_q;
  assign mac_clear   = mac_clear_q;
  assign mac_enable  = mac_enable_q;
  assign pass_count  = pass_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: table of whole frames plus
// hand-written resync, mid-frame reset and pass-count wrap sequences.
module tb_matrix_operand_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic in_clear = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready;
  logic [0:3][0:3][7:0] matrix_1, matrix_2;
  logic mac_clear, mac_enable, frame_error;
  logic [7:0] pass_count;

  matrix_operand_loader #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .in_clear(in_clear),
    .matrix_1(matrix_1), .matrix_2(matrix_2), .mac_clear(mac_clear),
    .mac_enable(mac_enable), .pass_count(pass_count), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  bit rnd_valid = 1'b0;
  logic [7:0] exp_a [16];
  logic [7:0] exp_b [16];

  always @(negedge clock) begin
    if (mac_enable === 1'b1) en_cnt++;
    if (mac_clear === 1'b1) clr_cnt++;
  end

  typedef struct {
    logic [7:0] a_seed;
    logic [7:0] b_seed;
    logic [7:0] b_step;
    logic       clr;
    logic [7:0] exp_pass;
    logic [7:0] exp_a12;
    logic [7:0] exp_b33;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic f, input logic c);
    int waited = 0;
    logic ok = 1'b0;
    if (rnd_valid) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_first = 1'($urandom);
        in_clear = 1'($urandom);
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b1; in_data = d; in_first = f; in_clear = c;
    do begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
      waited++;
    end while (ok !== 1'b1 && waited < 50);
    if (ok !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got ready=%b expected 1", ok);
    end
    in_valid = 1'b0; in_first = 1'b0; in_clear = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a_seed, input logic [7:0] b_seed,
                            input logic [7:0] b_step, input logic clr);
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = a_seed + 8'(i);
      send_beat(exp_a[i], i == 0, (i == 0) ? clr : 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = b_seed + 8'(i) * b_step;
      send_beat(exp_b[i], 1'b0, 1'b0);
    end
  endtask

  // Called in the cycle right after the last B beat was accepted.
  task automatic observe(input string tag, input logic clr);
    int gap = 0, clr_at = 0, en_at = 0, en_n = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (in_ready !== 1'b1) gap++;
      if (mac_clear === 1'b1) clr_at = k;
      if (mac_enable === 1'b1) begin en_at = k; en_n++; end
    end
    @(posedge clock); #1;
    chk({tag, " clear_cycle"}, clr_at, clr ? 1 : 0);
    chk({tag, " enable_cycle"}, en_at, clr ? 2 : 1);
    chk({tag, " enable_pulses"}, en_n, 1);
    chk({tag, " ready_gap"}, gap, clr ? 2 : 1);
  endtask

  task automatic check_mats(input string tag);
    int bad_a = 0, bad_b = 0;
    for (int i = 0; i < 16; i++) begin
      if (matrix_1[i/4][i%4] !== exp_a[i]) bad_a++;
      if (matrix_2[i/4][i%4] !== exp_b[i]) bad_b++;
    end
    chk({tag, " matrix_1_bad_elems"}, bad_a, 0);
    chk({tag, " matrix_2_bad_elems"}, bad_b, 0);
  endtask

  task automatic check_reset_state(input string tag);
    int nz = 0;
    for (int i = 0; i < 16; i++) begin
      if (matrix_1[i/4][i%4] !== 8'd0) nz++;
      if (matrix_2[i/4][i%4] !== 8'd0) nz++;
    end
    chk({tag, " matrices_nonzero"}, nz, 0);
    chk({tag, " pass_count"}, pass_count, 0);
    chk({tag, " frame_error"}, frame_error, 0);
    chk({tag, " mac_clear"}, mac_clear, 0);
    chk({tag, " mac_enable"}, mac_enable, 0);
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, c0;
    vecs[0] = '{8'd1,   8'd2,   8'd0,  1'b1, 8'd1, 8'd7,   8'd2};
    vecs[1] = '{8'd16,  8'd100, 8'd1,  1'b0, 8'd2, 8'd22,  8'd115};
    vecs[2] = '{8'd200, 8'd250, 8'd3,  1'b0, 8'd3, 8'd206, 8'd39};
    vecs[3] = '{8'd128, 8'd0,   8'd17, 1'b0, 8'd4, 8'd134, 8'd255};
    vecs[4] = '{8'd5,   8'd9,   8'd1,  1'b1, 8'd1, 8'd11,  8'd24};

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check_reset_state("reset");

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].a_seed, vecs[v].b_seed, vecs[v].b_step, vecs[v].clr);
      observe($sformatf("vec%0d", v), vecs[v].clr);
      chk($sformatf("vec%0d pass_count", v), pass_count, vecs[v].exp_pass);
      chk($sformatf("vec%0d a12", v), matrix_1[1][2], vecs[v].exp_a12);
      chk($sformatf("vec%0d b33", v), matrix_2[3][3], vecs[v].exp_b33);
      chk($sformatf("vec%0d frame_error", v), frame_error, 0);
      check_mats($sformatf("vec%0d", v));
    end

    // Gappy valid: same frame as vec1, only handshaked beats may land
    rnd_valid = 1'b1;
    send_frame(8'd16, 8'd100, 8'd1, 1'b0);
    rnd_valid = 1'b0;
    observe("gappy", 1'b0);
    chk("gappy pass_count", pass_count, 2);
    chk("gappy a12", matrix_1[1][2], 22);
    check_mats("gappy");

    // Resync on beat 20 (B index 4)
    e0 = en_cnt;
    for (int i = 0; i < 16; i++) send_beat(8'h30 + 8'(i), i == 0, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'h40 + 8'(i), 1'b0, 1'b0);
    send_beat(8'h55, 1'b1, 1'b0);
    chk("resync frame_error", frame_error, 1);
    chk("resync m1_00", matrix_1[0][0], 8'h55);
    exp_a[0] = 8'h55;
    for (int i = 1; i < 16; i++) begin
      exp_a[i] = 8'h60 + 8'(i);
      send_beat(exp_a[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = 8'h70 + 8'(i);
      send_beat(exp_b[i], 1'b0, 1'b0);
    end
    chk("resync no_early_enable", en_cnt - e0, 0);
    observe("resync", 1'b0);
    chk("resync pass_count", pass_count, 3);
    chk("resync frame_error_sticky", frame_error, 1);
    check_mats("resync");

    // Reset at beat 10 of a clear frame
    for (int i = 0; i < 10; i++) send_beat(8'h90 + 8'(i), i == 0, i == 0);
    e0 = en_cnt; c0 = clr_cnt;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check_reset_state("midreset");
    repeat (5) @(posedge clock);
    #1;
    chk("midreset no_enable", en_cnt - e0, 0);
    chk("midreset no_clear", clr_cnt - c0, 0);
    send_frame(8'd50, 8'd60, 8'd2, 1'b0);
    observe("postreset", 1'b0);
    chk("postreset enable_total", en_cnt - e0, 1);
    chk("postreset pass_count", pass_count, 1);
    check_mats("postreset");

    // 255 more passes: count reaches 255 then wraps to 0
    for (int k = 1; k <= 255; k++) begin
      send_frame(8'(k), 8'(255 - k), 8'd1, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      if (k == 254) chk("wrap pass_255", pass_count, 255);
      if (k == 255) chk("wrap pass_0", pass_count, 0);
    end
    chk("wrap frame_error", frame_error, 0);
    check_mats("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

- Stream-side writer for `matrix_mac_unit`. Accepts a valid/ready byte stream of 32 elements: matrix_1 then matrix_2, each 4x4 in row-major order.
- Assembles both operand matrices in registers and drives them to the MAC. Issues the MAC's one-cycle `clear` and `enable` strobes in the order the MAC's accumulator priority requires.
- Counts accumulation passes and flags framing errors. Sits between the operand DMA/stream fabric and the MAC unit.

## Interface
- `DATA_WIDTH`, 8, element width; must match the MAC's `DATA_WIDTH`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `in_valid`  in  1  stream beat valid.
- `in_ready`  out  1  loader can accept a beat.
- `in_data`  in  DATA_WIDTH  element value.
- `in_first`  in  1  marks element A[0][0] of a frame.
- `in_clear`  in  1  request accumulator clear before this frame's pass; honoured only with `in_first`.
- `matrix_1`  out  DATA_WIDTH x [0:3][0:3]  operand A to the MAC.
- `matrix_2`  out  DATA_WIDTH x [0:3][0:3]  operand B to the MAC.
- `mac_clear`  out  1  one-cycle clear strobe to the MAC.
- `mac_enable`  out  1  one-cycle enable strobe to the MAC.
- `pass_count`  out  8  passes issued since the last clear.
- `frame_error`  out  1  sticky framing error.

## Operation
- FSM states: LOAD_A, LOAD_B, CLEAR, FIRE. Reset state is LOAD_A.
- Element index is a 4-bit counter `idx`: row = `idx[3:2]`, col = `idx[1:0]`.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = 1 in LOAD_A and LOAD_B, 0 in CLEAR and FIRE.
- LOAD_A: each accepted beat writes `matrix_1[row][col]` and increments `idx`.
  - If the beat has `in_first`, `clear_pending` <= `in_clear`.
  - On the beat with `idx` = 15, `idx` wraps to 0 and the FSM goes to LOAD_B.
- LOAD_B: each accepted beat writes `matrix_2[row][col]`.
  - On the beat with `idx` = 15, go to CLEAR if `clear_pending`, else go to FIRE.
- CLEAR: `mac_clear` = 1 for one cycle. `pass_count` <= 0, `clear_pending` <= 0. Go to FIRE.
- FIRE: `mac_enable` = 1 for one cycle. `pass_count` <= `pass_count` + 1, wrapping 255 -> 0. Go to LOAD_A.
- Resync: an accepted beat with `in_first` = 1 while `idx` != 0, or while in LOAD_B, is handled as follows:
  - It sets `frame_error`.
  - It is written as `matrix_1[0][0]`.
  - `idx` <= 1, the FSM goes to LOAD_A, and `clear_pending` <= `in_clear`.
- A beat with `in_first` = 0 at LOAD_A `idx` 0 is accepted normally, with no error. `clear_pending` is unchanged.
- Matrix registers change only on accepted beats. They therefore hold stable through CLEAR and FIRE.
- `frame_error` stays set until reset.
- Simultaneous events: none exist. No beat can be accepted in CLEAR or FIRE, so strobes and writes never coincide.

## Timing
- Reset values (after the edge with `reset` = 0): matrices all 0, `mac_clear` 0, `mac_enable` 0, `pass_count` 0, `frame_error` 0, `clear_pending` 0, `idx` 0, state LOAD_A.
  - `in_ready` = 1 from the first cycle after reset.
- `mac_clear` and `mac_enable` are registered, state-decoded outputs. Each is high for exactly one cycle.
- Last B beat accepted at edge N:
  - With clear: `mac_clear` high in cycle N+1, `mac_enable` high in cycle N+2, `in_ready` back to 1 in cycle N+3.
  - Without clear: `mac_enable` high in cycle N+1, `in_ready` back to 1 in cycle N+2.
- Throughput: one frame per 33 cycles (34 with clear) under continuous `in_valid`.
- Reset asserted mid-frame: at the next edge, all state returns to reset values and partial-frame data is discarded. No strobe is emitted.

## Structure
- Shared package `matrix_mac_pkg`:
  - `MATRIX_DIM` = 4 and `ELEMS` = 16.
  - Loader state enum `loader_state_e`.
  - Typedef `matrix_t` for the 4x4 DATA_WIDTH array, so the loader and `matrix_mac_unit` ports agree.
- Single module; no sub-module needed.
- The 4-bit index counter stays inline.

## Test plan
- After reset, stream A = 1..16 and B = all 2, with `in_first`=1 and `in_clear`=1 on beat 0.
  - `mac_clear` pulses 1 cycle after the 32nd beat, then `mac_enable` the next cycle.
  - `matrix_1[1][2]` = 7; `pass_count` = 1.
- Send three back-to-back frames without clear, then a frame with `in_clear`=1.
  - `pass_count` goes 2, 3, 4, then 1.
  - `in_ready` is low exactly 1 cycle per no-clear frame and 2 cycles for the clear frame.
- Toggle `in_valid` randomly at 50%.
  - Only handshaked beats are written; matrices are identical to the gap-free case.
- Assert `in_first` on beat 20 (B index 4).
  - `frame_error` = 1; that beat lands in `matrix_1[0][0]`.
  - `mac_enable` fires only after 31 further beats.
- Assert reset at beat 10.
  - All outputs return to reset values and no strobe is emitted.
  - The next full frame produces exactly one `mac_enable`.
- Run 256 passes without clear.
  - `pass_count` wraps 255 -> 0 with no error.
